// File: rtl/arb_muxn.sv
// arb_muxn: registered CHANNELS-way mux with valid/ready handshakes on
// every input and the output. Arbitration is round-robin or fixed priority.
// One output register stage gives full throughput under backpressure.

// Per-channel helper: a channel is "upper" when it is valid and sits at or
// above the round-robin pointer. The first upper channel wins. If no channel
// is upper, the search wraps around and the lowest valid channel wins.
module arb_muxn_lane #(
   parameter int GW  = 2,
   parameter int IDX = 0
) (
   input  logic          valid,
   input  logic [GW-1:0] ptr,
   output logic          hi
);
   localparam logic [GW-1:0] IDX_W = GW'(IDX);

   assign hi = valid && (IDX_W >= ptr);
endmodule

module arb_muxn #(
   parameter int N           = 16,
   parameter int CHANNELS    = 4,
   parameter int ROUND_ROBIN = 1,
   parameter int GW          = $clog2(CHANNELS)
) (
   input  logic                  CLOCK,
   input  logic                  RESET,
   input  logic [CHANNELS-1:0]   VALID_IN,
   input  logic [CHANNELS*N-1:0] D,
   output logic [CHANNELS-1:0]   READY_IN,
   output logic [N-1:0]          Y,
   output logic [GW-1:0]         GRANT,
   output logic                  VALID_OUT,
   input  logic                  READY_OUT
);
   logic [CHANNELS-1:0][N-1:0] dv;
   logic [CHANNELS-1:0]        hi;
   logic [GW-1:0]              ptr;
   logic [GW-1:0]              win, win_hi, win_lo, ptr_nxt;
   logic                       any_hi, any, load;

   assign dv   = D;
   assign any  = |VALID_IN;
   assign load = !VALID_OUT || READY_OUT;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      arb_muxn_lane #(.GW(GW), .IDX(i)) u_lane (
         .valid (VALID_IN[i]),
         .ptr   (ptr),
         .hi    (hi[i])
      );
   end

   // Two-pass priority encode: the first valid channel at or above the
   // pointer wins. Otherwise the lowest valid channel wins. In fixed-priority
   // mode the pointer stays at 0, so this reduces to lowest-valid-wins.
   always_comb begin
      win_hi = '0;
      win_lo = '0;
      any_hi = 1'b0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (hi[i]) begin
            win_hi = GW'(i);
            any_hi = 1'b1;
         end
         if (VALID_IN[i]) win_lo = GW'(i);
      end
      win = any_hi ? win_hi : win_lo;
   end

   // The pointer wraps explicitly, so it never reaches CHANNELS when
   // CHANNELS is not a power of two.
   assign ptr_nxt = (win == GW'(CHANNELS - 1)) ? '0 : win + 1'b1;

   // Accept one-hot to the winner. Hold off during reset so no transfer is
   // seen on the reset edge.
   always_comb begin
      READY_IN = '0;
      if (!RESET && load && any) READY_IN[win] = 1'b1;
   end

   // Output register stage and round-robin pointer.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         Y         <= '0;
         GRANT     <= '0;
         VALID_OUT <= 1'b0;
         ptr       <= '0;
      end else if (load) begin
         if (any) begin
            Y         <= dv[win];
            GRANT     <= win;
            VALID_OUT <= 1'b1;
            if (ROUND_ROBIN != 0) ptr <= ptr_nxt;
         end else begin
            VALID_OUT <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_arb_muxn.sv
// Bench for arb_muxn. A round-robin instance and a fixed-priority instance
// share one set of inputs. Each instance is checked on every cycle against a
// behavioural model, and directed scenarios pin the model with literal values.
module tb_arb_muxn;
   localparam int N  = 16;
   localparam int CH = 4;
   localparam int GW = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [CH-1:0]        vin;
   logic [CH-1:0][N-1:0] d;
   logic                 rdy;

   logic [CH-1:0] rin_rr, rin_fp;
   logic [N-1:0]  y_rr, y_fp;
   logic [GW-1:0] g_rr, g_fp;
   logic          vo_rr, vo_fp;

   int nvec = 0;
   int nerr = 0;
   bit chk_en = 1'b0;

   // Model state per instance: index 0 is fixed priority, index 1 is round-robin.
   logic [N-1:0] m_y [2];
   int           m_g [2];
   bit           m_vo[2];
   int           m_ptr[2];

   always #5 clk = ~clk;

   arb_muxn #(.N(N), .CHANNELS(CH), .ROUND_ROBIN(1)) u_rr (
      .CLOCK(clk), .RESET(rst), .VALID_IN(vin), .D(d), .READY_IN(rin_rr),
      .Y(y_rr), .GRANT(g_rr), .VALID_OUT(vo_rr), .READY_OUT(rdy)
   );

   arb_muxn #(.N(N), .CHANNELS(CH), .ROUND_ROBIN(0)) u_fp (
      .CLOCK(clk), .RESET(rst), .VALID_IN(vin), .D(d), .READY_IN(rin_fp),
      .Y(y_fp), .GRANT(g_fp), .VALID_OUT(vo_fp), .READY_OUT(rdy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Return the first valid channel in search order. Search starts at ptr for
   // round-robin and at 0 for fixed priority. Return -1 if no channel is valid.
   function automatic int winner(input int m);
      int start;
      start = (m == 1) ? m_ptr[1] : 0;
      for (int k = 0; k < CH; k++) begin
         int idx;
         idx = (start + k) % CH;
         if (vin[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [CH-1:0] exp_ready(input int m);
      int w;
      if (rst) return '0;
      if (m_vo[m] && !rdy) return '0;
      w = winner(m);
      if (w < 0) return '0;
      return CH'(1) << w;
   endfunction

   // Model update on the active edge. Stimulus moves 1 time unit after the
   // edge, so the model reads the inputs that the DUT registers.
   always @(posedge clk) begin
      for (int m = 0; m < 2; m++) begin
         int w;
         if (rst) begin
            m_y[m] = '0; m_g[m] = 0; m_vo[m] = 1'b0; m_ptr[m] = 0;
         end else if (!m_vo[m] || rdy) begin
            w = winner(m);
            if (w >= 0) begin
               m_y[m]  = d[w];
               m_g[m]  = w;
               m_vo[m] = 1'b1;
               if (m == 1) m_ptr[m] = (w + 1) % CH;
            end else begin
               m_vo[m] = 1'b0;
            end
         end
      end
   end

   // Compare both instances against the model away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("rr_valid_out", 32'(vo_rr), 32'(m_vo[1]));
         chk("rr_ready_in",  32'(rin_rr), 32'(exp_ready(1)));
         chk("fp_valid_out", 32'(vo_fp), 32'(m_vo[0]));
         chk("fp_ready_in",  32'(rin_fp), 32'(exp_ready(0)));
         if (m_vo[1]) begin
            chk("rr_y", 32'(y_rr), 32'(m_y[1]));
            chk("rr_grant", 32'(g_rr), 32'(m_g[1]));
         end
         if (m_vo[0]) begin
            chk("fp_y", 32'(y_fp), 32'(m_y[0]));
            chk("fp_grant", 32'(g_fp), 32'(m_g[0]));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; vin = '0; d = '0; rdy = 1'b0;
      cyc();
      chk_en = 1'b1;
      cyc();
      rst = 1'b0;

      // Reset state, then a single channel.
      chk("reset_y", 32'(y_rr), 32'h0);
      chk("reset_vo", 32'(vo_rr), 32'h0);
      chk("reset_grant", 32'(g_rr), 32'h0);
      vin = 4'b0100; d[2] = 16'h234f; rdy = 1'b1;
      #1 chk("single_ready_in", 32'(rin_rr), 32'h4);
      cyc();
      chk("single_y", 32'(y_rr), 32'h234f);
      chk("single_grant", 32'(g_rr), 32'h2);
      chk("single_vo", 32'(vo_rr), 32'h1);

      // Round-robin fairness: all channels valid, consumer always ready.
      do_reset();
      vin = 4'b1111;
      for (int i = 0; i < CH; i++) d[i] = 16'h0100 + 16'(i);
      for (int k = 0; k < 8; k++) begin
         cyc();
         chk("fair_grant", 32'(g_rr), 32'(k % 4));
         chk("fair_y", 32'(y_rr), 32'h0100 + 32'(k % 4));
      end

      // Fixed priority: the lower valid channel always wins.
      vin = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         #1 chk("fp_no_ch3", 32'(rin_fp[3]), 32'h0);
         cyc();
         chk("fp_grant", 32'(g_fp), 32'h1);
      end

      // Backpressure: the held word survives while the consumer stalls.
      do_reset();
      vin = 4'b0001; d[0] = 16'h8000;
      cyc();
      rdy = 1'b0; vin = 4'b0010; d[1] = 16'hfeac;
      for (int k = 0; k < 3; k++) begin
         #1 chk("bp_ready_in", 32'(rin_rr), 32'h0);
         cyc();
         chk("bp_y_hold", 32'(y_rr), 32'h8000);
         chk("bp_vo", 32'(vo_rr), 32'h1);
      end
      rdy = 1'b1;
      #1 chk("bp_release_ready", 32'(rin_rr), 32'h2);
      cyc();
      chk("bp_y_new", 32'(y_rr), 32'hfeac);
      chk("bp_grant_new", 32'(g_rr), 32'h1);
      chk("bp_vo_new", 32'(vo_rr), 32'h1);

      // Skip and wrap: a grant to 2 leaves the pointer at 3. Only channel 0
      // is valid, so the search wraps to it.
      do_reset();
      vin = 4'b0100;
      cyc();
      vin = 4'b0001;
      cyc();
      chk("wrap_grant0", 32'(g_rr), 32'h0);
      vin = 4'b0011;
      cyc();
      chk("wrap_grant1", 32'(g_rr), 32'h1);

      // Reset in the middle of a continuous stream.
      vin = 4'b1111;
      for (int k = 0; k < 5; k++) cyc();
      rst = 1'b1;
      #1 chk("mid_rst_ready", 32'(rin_rr), 32'h0);
      cyc();
      chk("mid_rst_vo", 32'(vo_rr), 32'h0);
      chk("mid_rst_y", 32'(y_rr), 32'h0);
      chk("mid_rst_grant", 32'(g_rr), 32'h0);
      rst = 1'b0;
      cyc();
      chk("post_rst_grant", 32'(g_rr), 32'h0);
      chk("post_rst_vo", 32'(vo_rr), 32'h1);

      // Random traffic, checked by the per-cycle compare process.
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(0, 59) == 0);
         vin = CH'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) vin = '0;
         rdy = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < CH; i++) d[i] = N'($urandom);
         cyc();
      end

      rst = 1'b0;
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/arb_muxn.md
# arb_muxn

Parametrised, registered N-way multiplexer with per-channel valid/ready handshakes and selectable round-robin or fixed-priority arbitration. It generalises the 2:1 combinational mux to CHANNELS inputs of width N. One output register stage provides full throughput and backpressure. It sits between multiple producers (register-file read ports, ALU/memory result buses) and a single consumer in the datapath.

## Interface
- N, 16, data width in bits per channel.
- CHANNELS, 4, number of input channels; legal range 2..16.
- ROUND_ROBIN, 1, arbitration mode: 1 selects round-robin, 0 selects fixed priority (lowest index wins).
- GW, $clog2(CHANNELS), derived width of the grant index; not overridden.

Ports:
- CLOCK  input  1  single clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- VALID_IN  input  CHANNELS  bit i high means channel i presents data.
- D  input  CHANNELS*N  packed inputs; channel i occupies D[i*N +: N].
- READY_IN  output  CHANNELS  one-hot or zero; bit i high means channel i's data is accepted this cycle.
- Y  output  N  registered selected data.
- GRANT  output  GW  registered index of the channel whose data is in Y.
- VALID_OUT  output  1  Y/GRANT hold an unconsumed word.
- READY_OUT  input  1  consumer accepts Y this cycle.

## Operation
- Load enable is LOAD = !VALID_OUT || READY_OUT, which allows a pass-through pipeline.
- Arbitration is combinational over VALID_IN:
  - Round-robin: search starts at pointer PTR and proceeds upward, wrapping modulo CHANNELS. The first valid index is the winner W.
  - Fixed priority: W is the lowest valid index, and PTR is ignored.
- READY_IN[W] = LOAD && |VALID_IN. All other bits are 0. READY_IN never depends on READY_IN of any other channel.
- A transfer on channel i occurs when VALID_IN[i] && READY_IN[i] at an edge. On that edge:
  - Y <= D[W]
  - GRANT <= W
  - VALID_OUT <= 1
  - PTR <= (W+1) mod CHANNELS. PTR is updated in round-robin mode only.
- When LOAD is high and no VALID_IN bit is set: VALID_OUT <= 0, Y and GRANT hold their values, PTR holds.
- When LOAD is low (VALID_OUT && !READY_OUT): Y, GRANT, VALID_OUT and PTR all hold, and READY_IN = 0.
- PTR advances only on an actual grant, never on idle cycles.
- Producers must keep VALID_IN[i] and D[i] stable until accepted. The block does not rely on this for correctness; it samples D only on the accept edge.

## Timing
- Reset values (RESET high at an edge): Y = 0, GRANT = 0, VALID_OUT = 0, PTR = 0. READY_IN is 0 during the reset cycle. RESET has priority over every other event.
- Reset mid-operation discards any word held in Y. No transfer is counted on the reset edge, even if VALID_IN and READY_OUT are high.
- Latency: a word accepted at edge k appears with VALID_OUT = 1 after edge k, i.e. 1 cycle.
- Throughput: one word per cycle when READY_OUT stays high.
- Simultaneous consume and refill: if VALID_OUT && READY_OUT and some VALID_IN is set, the old word is consumed and the new word is loaded on the same edge, so VALID_OUT stays 1.
- Wrap-around: with PTR = CHANNELS-1, a grant to CHANNELS-1 sets PTR to 0.
- Fairness: in round-robin mode, with all channels continuously valid and READY_OUT = 1, grants cycle 0,1,..,CHANNELS-1,0,...
- CHANNELS not a power of two: PTR and GRANT never take values ≥ CHANNELS.

## Test plan
- Reset, then single channel: RESET high for 2 cycles; check Y = 0, VALID_OUT = 0, GRANT = 0. Then VALID_IN = 4'b0100, D[2] = 16'h234f, READY_OUT = 1. Required: READY_IN = 4'b0100 in the same cycle, and one cycle later Y = 16'h234f, GRANT = 2, VALID_OUT = 1.
- Round-robin fairness: VALID_IN = 4'b1111 with D[i] = 16'h0100+i, READY_OUT = 1 for 8 cycles. Required: GRANT sequence 0,1,2,3,0,1,2,3 and Y = 16'h0100..16'h0103 repeating.
- Fixed priority (ROUND_ROBIN = 0): VALID_IN = 4'b1010 held for 4 cycles. Required: GRANT = 1 every cycle, and READY_IN[3] is never high.
- Backpressure: load 16'h8000 from channel 0, then READY_OUT = 0 for 3 cycles while VALID_IN = 4'b0010 with D[1] = 16'hfeac. Required: Y holds 16'h8000, READY_IN = 0, PTR unchanged. When READY_OUT rises, the next edge gives Y = 16'hfeac, GRANT = 1, and VALID_OUT stays 1 throughout.
- Skip and wrap: PTR = 3, VALID_IN = 4'b0001. Required: GRANT = 0, and next-cycle PTR = 1 (verified by then asserting VALID_IN = 4'b0011 and checking GRANT = 1).
- Reset mid-stream: during a continuous 4-channel stream with READY_OUT = 1, pulse RESET for one cycle. Required: the next cycle has VALID_OUT = 0, Y = 0, GRANT = 0, and READY_IN = 0 during reset. The first grant after reset is channel 0.
